// File: rtl/filt_scan.sv
`default_nettype none
// filt_scan: round-robin debounce controller sharing one hysteresis filter
// across N inputs; confirmed level changes are reported on a valid/ready port.
module filt_scan #(
  parameter int N  = 8,
  parameter int CW = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i,
  input  logic          en,
  input  logic [CW-1:0] thr,
  output logic [N-1:0]  y,
  output logic [PW-1:0] scan_idx,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [PW-1:0] evt_ch,
  output logic          evt_lvl,
  input  logic          ovf_clr,
  output logic          ovf
);

  localparam logic [1:0]    Z0       = 2'd0;
  localparam logic [1:0]    Z1       = 2'd1;
  localparam logic [1:0]    E0       = 2'd2;
  localparam logic [1:0]    E1       = 2'd3;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] P_LAST   = PW'(N - 1);

  logic [N-1:0]  sync1, sync2;
  logic [PW-1:0] p;
  logic [1:0]    st  [N];
  logic [CW-1:0] cnt [N];

  logic [1:0]    cur_st, nxt_st;
  logic [CW-1:0] cur_cnt, nxt_cnt, cnt_inc;
  logic          sp, raise, lvl, raise_en, load, drop;

  assign scan_idx = p;

  // Shared filter engine: evaluates only the channel under the scan pointer.
  always_comb begin
    cur_st  = st[p];
    cur_cnt = cnt[p];
    sp      = sync2[p];
    nxt_st  = cur_st;
    nxt_cnt = cur_cnt;
    raise   = 1'b0;
    lvl     = 1'b0;
    cnt_inc = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
    case (cur_st)
      Z0: if (sp) begin
        nxt_st  = Z1;
        nxt_cnt = '0;
      end
      Z1: if (cur_cnt >= thr) begin
        nxt_st = E0;
        raise  = 1'b1;
        lvl    = 1'b1;
      end else if (!sp) begin
        nxt_st  = Z0;
        nxt_cnt = '0;
      end else begin
        nxt_cnt = cnt_inc;
      end
      E0: if (!sp) begin
        nxt_st  = E1;
        nxt_cnt = '0;
      end
      E1: if (cur_cnt >= thr) begin
        nxt_st = Z0;
        raise  = 1'b1;
        lvl    = 1'b0;
      end else if (sp) begin
        nxt_st  = E0;
        nxt_cnt = '0;
      end else begin
        nxt_cnt = cnt_inc;
      end
      default: nxt_st = Z0;
    endcase
  end

  // The slot frees in the same cycle it is accepted, so back-to-back loads work.
  assign raise_en = en & raise;
  assign load     = raise_en & (~evt_valid | evt_ready);
  assign drop     = raise_en & ~load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      p         <= '0;
      y         <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_lvl   <= 1'b0;
      ovf       <= 1'b0;
      for (int c = 0; c < N; c++) begin
        st[c]  <= Z0;
        cnt[c] <= '0;
      end
    end else begin
      sync1 <= i;
      sync2 <= sync1;
      if (en) begin
        st[p]  <= nxt_st;
        cnt[p] <= nxt_cnt;
        if (raise) y[p] <= lvl;
        p <= (p == P_LAST) ? '0 : p + 1'b1;
      end
      if (load) begin
        evt_valid <= 1'b1;
        evt_ch    <= p;
        evt_lvl   <= lvl;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire
